// File: rtl/axi_lite_mem_master_if.sv
// AXI-Lite bus bundle between the memory master and the CPU slave port.
// The master modport drives the address/data/valid side; the slave modport
// drives the ready/response side.
interface axi_lite_mem_master_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [31:0]           m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wstrb;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;

  modport master (
    output m_araddr, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready,
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready
  );

  modport slave (
    input  m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready,
    input  m_awaddr, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready
  );
endinterface

// File: rtl/axi_lite_mem_master.sv
// AXI-Lite initiator with a one-outstanding command/response front end.
// Optional watchdog: define AXI_MST_TIMEOUT_EN to abort a stalled channel wait
// after TIMEOUT_CYCLES with rsp_resp=2'b11 and rsp_rdata=32'hDEAD_BEEF.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | cmd_ready high, waiting for a command
// S_RD_A  | arvalid high until the AR handshake
// S_RD_D  | rready high until read data arrives
// S_WR_AW | awvalid/wvalid high, each until its own handshake
// S_WR_B  | bready high until the write response arrives
// S_RSP   | rsp_valid high until the consumer takes it
module axi_lite_mem_master #(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  axi_lite_mem_master_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_D,
    S_WR_AW,
    S_WR_B,
    S_RSP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  write_q;
  logic [31:0]           rdata_q;
  logic [1:0]            resp_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  aw_fin;
  logic                  w_fin;
  logic                  tmo_hit;
  logic                  tmo_abort;

  assign aw_fin = aw_done_q | (axi.m_awvalid & axi.m_awready);
  assign w_fin  = w_done_q | (axi.m_wvalid & axi.m_wready);

`ifdef AXI_MST_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          in_wait;

  assign in_wait = (state_q == S_RD_A) || (state_q == S_RD_D) ||
                   (state_q == S_WR_AW) || (state_q == S_WR_B);
  assign tmo_hit = in_wait && (tmo_cnt_q == '0);

  // Watchdog down-counter; reloads on every state change so each wait phase gets a full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= TMO_LOAD;
    end else if (!in_wait || (state_d != state_q)) begin
      tmo_cnt_q <= TMO_LOAD;
    end else if (tmo_cnt_q != '0) begin
      tmo_cnt_q <= tmo_cnt_q - TW'(1);
    end
  end
`else
  // No watchdog in this build: waits are unbounded; the limit can never be reached.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a real handshake always wins over a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    tmo_abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = cmd_write ? S_WR_AW : S_RD_A;
        end
      end
      S_RD_A: begin
        if (axi.m_arready) begin
          state_d = S_RD_D;
        end else if (tmo_hit) begin
          state_d   = S_RSP;
          tmo_abort = 1'b1;
        end
      end
      S_RD_D: begin
        if (axi.m_rvalid) begin
          state_d = S_RSP;
        end else if (tmo_hit) begin
          state_d   = S_RSP;
          tmo_abort = 1'b1;
        end
      end
      S_WR_AW: begin
        if (aw_fin && w_fin) begin
          state_d = S_WR_B;
        end else if (tmo_hit) begin
          state_d   = S_RSP;
          tmo_abort = 1'b1;
        end
      end
      S_WR_B: begin
        if (axi.m_bvalid) begin
          state_d = S_RSP;
        end else if (tmo_hit) begin
          state_d   = S_RSP;
          tmo_abort = 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command capture, per-channel completion flags and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (tmo_abort) begin
      rdata_q <= 32'hDEAD_BEEF;
      resp_q  <= 2'b11;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            write_q   <= cmd_write;
            rdata_q   <= '0;
            resp_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        S_RD_D: begin
          if (axi.m_rvalid) begin
            rdata_q <= axi.m_rdata;
            resp_q  <= axi.m_rresp;
          end
        end
        S_WR_AW: begin
          if (axi.m_awvalid && axi.m_awready) aw_done_q <= 1'b1;
          if (axi.m_wvalid && axi.m_wready)   w_done_q  <= 1'b1;
        end
        S_WR_B: begin
          if (axi.m_bvalid) begin
            resp_q <= axi.m_bresp;
          end
        end
        default: ;
      endcase
    end
  end

  // Valids and readies come only from registered state, never from the far side's ready.
  assign cmd_ready     = (state_q == S_IDLE) && !rst;
  assign axi.m_arvalid = (state_q == S_RD_A);
  assign axi.m_rready  = (state_q == S_RD_D);
  assign axi.m_awvalid = (state_q == S_WR_AW) && !aw_done_q;
  assign axi.m_wvalid  = (state_q == S_WR_AW) && !w_done_q;
  assign axi.m_bready  = (state_q == S_WR_B);
  assign axi.m_araddr  = addr_q & WORD_MASK;
  assign axi.m_awaddr  = addr_q & WORD_MASK;
  assign axi.m_wdata   = wdata_q;
  assign axi.m_wstrb   = wstrb_q;

  assign rsp_valid = (state_q == S_RSP);
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Directed bench for axi_lite_mem_master: a table of single transactions against
// a small AXI-Lite slave model with programmable ready delays, plus hand-written
// sequences for reset in the middle of a write and a stalled AR channel.
module tb_axi_lite_mem_master;

`ifdef AXI_MST_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [13:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  axi_lite_mem_master_if #(.ADDR_WIDTH(14)) bus ();

  axi_lite_mem_master #(.ADDR_WIDTH(14), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axi       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- slave model (acts on falling edges) ----------------
  int          ar_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic        ar_block = 1'b0;
  logic [1:0]  slv_resp = 2'b00;
  logic [31:0] mem [0:4095];
  int          ar_seen = 0, aw_seen = 0, w_seen = 0, b_wait = 0;
  logic        ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  logic        aw_got = 0, w_got = 0, bpend = 0;
  logic [13:0] ar_a, aw_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;

  // Handshakes decided at one falling edge complete on the following rising edge,
  // since master outputs only move on rising edges.
  always @(negedge clk) begin
    if (rst) begin
      bus.m_arready = 0; bus.m_rvalid = 0; bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
      bus.m_rdata = 0; bus.m_rresp = 0; bus.m_bresp = 0;
      ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
      aw_got = 0; w_got = 0; bpend = 0; ar_seen = 0; aw_seen = 0; w_seen = 0; b_wait = 0;
    end else begin
      if (r_hs) bus.m_rvalid = 0;
      if (ar_hs) begin
        bus.m_rvalid = 1; bus.m_rdata = mem[ar_a[13:2]]; bus.m_rresp = slv_resp;
      end
      if (b_hs) begin bus.m_bvalid = 0; bpend = 0; end
      if (aw_hs) aw_got = 1;
      if (w_hs) w_got = 1;
      if (aw_got && w_got && !bpend) begin
        bpend = 1; b_wait = b_dly; aw_got = 0; w_got = 0;
      end
      if (bpend && !bus.m_bvalid) begin
        if (b_wait == 0) begin
          bus.m_bvalid = 1; bus.m_bresp = slv_resp;
          for (int b = 0; b < 4; b++)
            if (w_s[b]) mem[aw_a[13:2]][8*b +: 8] = w_d[8*b +: 8];
        end else begin
          b_wait--;
        end
      end
      if (bus.m_arvalid && !ar_block) begin bus.m_arready = (ar_seen >= ar_dly); ar_seen++; end
      else begin bus.m_arready = 0; if (!bus.m_arvalid) ar_seen = 0; end
      if (bus.m_awvalid) begin bus.m_awready = (aw_seen >= aw_dly); aw_seen++; end
      else begin bus.m_awready = 0; aw_seen = 0; end
      if (bus.m_wvalid) begin bus.m_wready = (w_seen >= w_dly); w_seen++; end
      else begin bus.m_wready = 0; w_seen = 0; end
      ar_hs = bus.m_arvalid && bus.m_arready;
      aw_hs = bus.m_awvalid && bus.m_awready;
      w_hs  = bus.m_wvalid && bus.m_wready;
      r_hs  = bus.m_rvalid && bus.m_rready;
      b_hs  = bus.m_bvalid && bus.m_bready;
      if (ar_hs) begin ar_a = bus.m_araddr; ar_seen = 0; end
      if (aw_hs) begin aw_a = bus.m_awaddr; aw_seen = 0; end
      if (w_hs) begin w_d = bus.m_wdata; w_s = bus.m_wstrb; w_seen = 0; end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    int          ar_d, aw_d, w_d, hold;
    logic [31:0] exp_rdata;
    int          exp_lat, exp_arv, exp_awv, exp_wv;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int          n, lat, arv, awv, wv, rr, br;
    logic        addr_ok, data_ok, stable_ok;
    logic [13:0] ea;
    logic [31:0] held;
    ea = {v.addr[13:2], 2'b00};
    slv_resp = v.resp; ar_dly = v.ar_d; aw_dly = v.aw_d; w_dly = v.w_d;
    @(negedge clk);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, {31'd0, cmd_ready}, 32'd1);
    lat = 0; arv = 0; awv = 0; wv = 0; rr = 0; br = 0; addr_ok = 1; data_ok = 1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) cmd_valid = 0;
      if (bus.m_arvalid) begin arv++; if (bus.m_araddr !== ea) addr_ok = 0; end
      if (bus.m_awvalid) begin awv++; if (bus.m_awaddr !== ea) addr_ok = 0; end
      if (bus.m_wvalid) begin
        wv++;
        if (bus.m_wdata !== v.wdata || bus.m_wstrb !== v.wstrb) data_ok = 0;
      end
      if (bus.m_rready) rr++;
      if (bus.m_bready) br++;
    end while (!rsp_valid && lat < 100);
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_arvalid_cycles"}, arv, v.exp_arv);
    chk({tag, "_awvalid_cycles"}, awv, v.exp_awv);
    chk({tag, "_wvalid_cycles"}, wv, v.exp_wv);
    chk({tag, "_rready_cycles"}, rr, v.wr ? 0 : 1);
    chk({tag, "_bready_cycles"}, br, v.wr ? 1 : 0);
    chk({tag, "_addr_stable"}, {31'd0, addr_ok}, 32'd1);
    chk({tag, "_wpayload_stable"}, {31'd0, data_ok}, 32'd1);
    chk({tag, "_rsp_write"}, {31'd0, rsp_write}, {31'd0, v.wr});
    chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, "_rsp_resp"}, {30'd0, rsp_resp}, {30'd0, v.resp});
    held = rsp_rdata; stable_ok = 1;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== held || cmd_ready) stable_ok = 0;
    end
    chk({tag, "_rsp_hold"}, {31'd0, stable_ok}, 32'd1);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, "_after_rsp"}, {30'd0, rsp_valid, cmd_ready}, 32'd1);
  endtask

  vec_t vecs[9];
  vec_t post;

  initial begin
    int n, arv;

    vecs[0] = '{1'b1, 14'h0010, 32'h1234_5678, 4'hF, 2'b00, 0, 0, 0, 0, 32'h0, 3, 0, 1, 1};
    vecs[1] = '{1'b0, 14'h0010, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 32'h1234_5678, 3, 1, 0, 0};
    vecs[2] = '{1'b1, 14'h0020, 32'hAABB_CCDD, 4'hF, 2'b00, 0, 3, 0, 0, 32'h0, 6, 0, 4, 1};
    vecs[3] = '{1'b0, 14'h0020, 32'h0, 4'h0, 2'b00, 0, 0, 0, 5, 32'hAABB_CCDD, 3, 1, 0, 0};
    vecs[4] = '{1'b1, 14'h0021, 32'h1122_3344, 4'b0101, 2'b10, 0, 0, 2, 0, 32'h0, 5, 0, 1, 3};
    vecs[5] = '{1'b0, 14'h0023, 32'h0, 4'h0, 2'b01, 2, 0, 0, 0, 32'hAA22_CC44, 5, 3, 0, 0};
    vecs[6] = '{1'b0, 14'h0010, 32'h0, 4'h0, 2'b00, 0, 0, 0, 2, 32'h1234_5678, 3, 1, 0, 0};
    vecs[7] = '{1'b1, 14'h3FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 0, 2, 1, 0, 32'h0, 5, 0, 3, 2};
    vecs[8] = '{1'b0, 14'h3FFF, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 32'hCAFE_F00D, 3, 1, 0, 0};
    post    = '{1'b0, 14'h0010, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 32'h1234_5678, 3, 1, 0, 0};

    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_handshake_outs", {26'd0, bus.m_arvalid, bus.m_awvalid, bus.m_wvalid,
                               bus.m_rready, bus.m_bready, rsp_valid}, 32'd0);
    chk("rst_rsp_fields", {rsp_rdata[29:0], rsp_resp}, 32'd0);
    chk("rst_addrs", {4'd0, bus.m_araddr, bus.m_awaddr}, 32'd0);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset asserted while waiting on B.
    ar_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 20; slv_resp = 2'b00;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 14'h0030; cmd_wdata = 32'h5566_7788; cmd_wstrb = 4'hF;
    chk("wrb_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    chk("wrb_bready", {31'd0, bus.m_bready}, 32'd1);
    #2 rst = 1;
    #1;
    chk("wrb_rst_outs", {25'd0, bus.m_arvalid, bus.m_awvalid, bus.m_wvalid, bus.m_rready,
                         bus.m_bready, rsp_valid, cmd_ready}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 0;
    b_dly = 0;
    @(negedge clk);
    chk("wrb_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    run_vec(post, "post_rst_read");

    // AR channel stalled by the slave.
    ar_block = 1; ar_dly = 0; slv_resp = 2'b00;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 14'h0010;
    chk("stall_accept", {31'd0, cmd_ready}, 32'd1);
    n = 0; arv = 0;
`ifdef AXI_MST_TIMEOUT_EN
    do begin
      @(negedge clk);
      n++;
      if (n == 1) cmd_valid = 0;
      if (bus.m_arvalid) arv++;
    end while (!rsp_valid && n < 100);
    chk("tmo_arvalid_cycles", arv, 16);
    chk("tmo_latency", n, 17);
    chk("tmo_arvalid_dropped", {31'd0, bus.m_arvalid}, 32'd0);
    chk("tmo_resp", {30'd0, rsp_resp}, 32'd3);
    chk("tmo_rdata", rsp_rdata, 32'hDEAD_BEEF);
`else
    repeat (40) begin
      @(negedge clk);
      n++;
      if (n == 1) cmd_valid = 0;
      if (bus.m_arvalid) arv++;
    end
    chk("stall_arvalid_held", arv, 40);
    chk("stall_no_rsp", {31'd0, rsp_valid}, 32'd0);
    ar_block = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
    chk("stall_rdata", rsp_rdata, 32'h1234_5678);
    chk("stall_resp", {30'd0, rsp_resp}, 32'd0);
`endif
    ar_block = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("stall_after_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
